// File: rtl/apb_slave_mem.sv
// APB slave backed by a small word-addressed memory.
//   PCLK/PRESETn           : clock, async active-low reset (clears memory too)
//   PSEL/PENABLE/PWRITE    : APB control
//   PADDR/PWDATA/PSTRB     : byte address, write data, byte enables
//   PRDATA/PREADY/PSLVERR  : read data, completion, error (valid only with PREADY)
module apb_slave_mem #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned MEM_DEPTH   = 64,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [STRB_WIDTH-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
  localparam int unsigned MIDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0]  WS     = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   strb_q, strb_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [MEM_DEPTH];

  logic [IDX_W-1:0]        idx;
  logic [MIDX_W-1:0]       midx;
  logic                    err;

  // Decode always works on the address latched at SETUP->ACCESS, so the
  // master may change PADDR once the transfer has been captured.
  always_comb begin
    idx  = addr_q[ADDR_WIDTH-1:2];
    midx = idx[MIDX_W-1:0];
    err  = (32'(idx) >= MEM_DEPTH) || (addr_q[1:0] != 2'b00);
  end

  always_comb begin
    PREADY  = (state_q == ACCESS) && (cnt_q == WS);
    PSLVERR = PREADY && err;
    PRDATA  = (PREADY && !err && !write_q) ? mem_q[midx] : '0;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) state_d = SETUP;
      end
      SETUP: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PENABLE) begin
          state_d = ACCESS;
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (PREADY) begin
          if (write_q && !err) begin
            for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
              if (strb_q[i]) mem_d[midx][i*8 +: 8] = wdata_q[i*8 +: 8];
            end
          end
          // Master already presenting the next setup phase: skip IDLE.
          state_d = (PSEL && !PENABLE) ? SETUP : IDLE;
        end else if (!PSEL || !PENABLE) begin
          state_d = IDLE;
        end else if (cnt_q < WS) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      cnt_q   <= '0;
      for (int unsigned w = 0; w < MEM_DEPTH; w++) mem_q[w] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: one instance with one wait state, one with none,
// sharing a bus; use_b steers PSEL and the observed outputs.
module tb_apb_slave_mem;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, psel, penable, pwrite, use_b;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          psel_a, psel_b;
  logic [DW-1:0] prdata_a, prdata_b, prdata;
  logic          pready_a, pready_b, pready;
  logic          pslverr_a, pslverr_b, pslverr;

  assign psel_a  = psel & ~use_b;
  assign psel_b  = psel & use_b;
  assign prdata  = use_b ? prdata_b  : prdata_a;
  assign pready  = use_b ? pready_b  : pready_a;
  assign pslverr = use_b ? pslverr_b : pslverr_a;

  apb_slave_mem #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW),
    .MEM_DEPTH(64), .WAIT_STATES(1)
  ) u_dut_ws1 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel_a), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a)
  );

  apb_slave_mem #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW),
    .MEM_DEPTH(64), .WAIT_STATES(0)
  ) u_dut_ws0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel_b), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic          b2b;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  typedef struct {
    string         name;
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[18];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    psel    = 1'b0;
    penable = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drives a setup phase now, then the access phase until PREADY. Leaves the
  // bus as-is on return so the caller can chain a back-to-back transfer.
  task automatic do_xfer(input string name, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                         input logic [DW-1:0] exp_rdata, input logic exp_err, input int exp_lat);
    exp_t e;
    int   cyc;
    bit   done;
    e.name  = name;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    sb_q.push_back(e);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    pstrb   = strb;
    @(posedge clk); #1;
    cyc     = 1;
    penable = 1'b1;
    done    = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (pready) done = 1'b1;
    end
    e = sb_q.pop_front();
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: PREADY not seen within 20 access cycles", e.name);
      psel    = 1'b0;
      penable = 1'b0;
    end else begin
      check({e.name, " prdata"}, prdata, e.rdata);
      check({e.name, " pslverr"}, {31'b0, pslverr}, {31'b0, e.err});
      check({e.name, " latency"}, cyc, e.lat);
    end
  endtask

  initial begin
    //          wr    addr     wdata          strb     b2b   exp_rdata      err
    vecs[0]  = '{1'b1, 9'h008, 32'hA5A5_1234, 4'hF,    1'b0, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 9'h008, 32'h0,         4'h0,    1'b0, 32'hA5A5_1234, 1'b0};
    vecs[2]  = '{1'b1, 9'h010, 32'hFFFF_FFFF, 4'b0101, 1'b0, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 9'h010, 32'h0,         4'h0,    1'b0, 32'h00FF_00FF, 1'b0};
    vecs[4]  = '{1'b1, 9'h100, 32'hDEAD_BEEF, 4'hF,    1'b0, 32'h0,         1'b1};
    vecs[5]  = '{1'b0, 9'h100, 32'h0,         4'h0,    1'b0, 32'h0,         1'b1};
    vecs[6]  = '{1'b1, 9'h006, 32'h1234_5678, 4'hF,    1'b0, 32'h0,         1'b1};
    vecs[7]  = '{1'b0, 9'h004, 32'h0,         4'h0,    1'b0, 32'h0,         1'b0};
    vecs[8]  = '{1'b0, 9'h000, 32'h0,         4'h0,    1'b0, 32'h0,         1'b0};
    vecs[9]  = '{1'b1, 9'h1FC, 32'h1122_3344, 4'hF,    1'b0, 32'h0,         1'b1};
    vecs[10] = '{1'b1, 9'h0FC, 32'h1122_3344, 4'hF,    1'b0, 32'h0,         1'b0};
    vecs[11] = '{1'b0, 9'h0FC, 32'h0,         4'h0,    1'b0, 32'h1122_3344, 1'b0};
    vecs[12] = '{1'b1, 9'h010, 32'hAABB_CCDD, 4'h0,    1'b0, 32'h0,         1'b0};
    vecs[13] = '{1'b0, 9'h010, 32'h0,         4'h0,    1'b0, 32'h00FF_00FF, 1'b0};
    vecs[14] = '{1'b1, 9'h010, 32'hAABB_CCDD, 4'b1010, 1'b0, 32'h0,         1'b0};
    vecs[15] = '{1'b0, 9'h010, 32'h0,         4'h0,    1'b0, 32'hAAFF_CCFF, 1'b0};
    vecs[16] = '{1'b1, 9'h004, 32'h0BAD_F00D, 4'hF,    1'b1, 32'h0,         1'b0};
    vecs[17] = '{1'b0, 9'h004, 32'h0,         4'h0,    1'b0, 32'h0BAD_F00D, 1'b0};

    rst_n   = 1'b0;
    use_b   = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    #1;
    check("reset pready", {31'b0, pready}, 32'h0);
    check("reset pslverr", {31'b0, pslverr}, 32'h0);
    check("reset prdata", prdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First transfer starts right after deassertion; latency proves acceptance.
    for (int i = 0; i < 18; i++) begin
      do_xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              vecs[i].strb, vecs[i].exp_rdata, vecs[i].exp_err, 3);
      if (!vecs[i].b2b) bus_idle();
    end

    // PSEL+PENABLE from IDLE must be ignored.
    psel    = 1'b1;
    penable = 1'b1;
    paddr   = 9'h008;
    pwrite  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("idle ignore pready", {31'b0, pready}, 32'h0);
    end
    bus_idle();
    do_xfer("after idle ignore", 1'b0, 9'h008, 32'h0, 4'h0, 32'hA5A5_1234, 1'b0, 3);
    bus_idle();

    // PSEL dropped in the wait state: abort, no write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h020;
    pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    check("abort wait pready", {31'b0, pready}, 32'h0);
    psel = 1'b0;
    @(posedge clk); #1;
    penable = 1'b0;
    check("abort idle pready", {31'b0, pready}, 32'h0);
    @(posedge clk); #1;
    do_xfer("abort readback", 1'b0, 9'h020, 32'h0, 4'h0, 32'h0, 1'b0, 3);
    bus_idle();

    // Reset while a write to 0x0C is completing.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h00C;
    pwdata = 32'h1234_5678; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre-reset pready", {31'b0, pready}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid reset pready", {31'b0, pready}, 32'h0);
    check("mid reset pslverr", {31'b0, pslverr}, 32'h0);
    psel    = 1'b0;
    penable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_xfer("post reset 0x0C", 1'b0, 9'h00C, 32'h0, 4'h0, 32'h0, 1'b0, 3);
    bus_idle();
    do_xfer("post reset 0x08", 1'b0, 9'h008, 32'h0, 4'h0, 32'h0, 1'b0, 3);
    bus_idle();

    // Zero-wait-state instance: PREADY in the first access cycle.
    use_b = 1'b1;
    do_xfer("ws0 write", 1'b1, 9'h008, 32'hCAFE_BABE, 4'hF, 32'h0, 1'b0, 2);
    bus_idle();
    do_xfer("ws0 read", 1'b0, 9'h008, 32'h0, 4'h0, 32'hCAFE_BABE, 1'b0, 2);
    bus_idle();
    do_xfer("ws0 misaligned", 1'b0, 9'h006, 32'h0, 4'h0, 32'h0, 1'b1, 2);
    bus_idle();
    do_xfer("ws0 b2b write", 1'b1, 9'h004, 32'h1357_9BDF, 4'b0011, 32'h0, 1'b0, 2);
    do_xfer("ws0 b2b read", 1'b0, 9'h004, 32'h0, 4'h0, 32'h0000_9BDF, 1'b0, 2);
    bus_idle();
    use_b = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
- REQ-001: Parameter ADDR_WIDTH, default 8, byte-address width of PADDR.
- REQ-002: Parameter DATA_WIDTH, default 32, width of PWDATA/PRDATA.
- REQ-003: Parameter STRB_WIDTH, default DATA_WIDTH/8, one strobe bit per data byte.
- REQ-004: Parameter MEM_DEPTH, default 64, number of DATA_WIDTH words; legal values SHALL be at most 2^(ADDR_WIDTH-2).
- REQ-005: Parameter WAIT_STATES, default 1, extra access-phase cycles before PREADY; range 0..15.
- REQ-006: PCLK  input  1  single block clock; all state SHALL update on its rising edge.
- REQ-007: PRESETn  input  1  reset, asynchronous assert, active-low.
- REQ-008: PSEL  input  1  slave select.
- REQ-009: PENABLE  input  1  access-phase indicator.
- REQ-010: PWRITE  input  1  1 = write, 0 = read.
- REQ-011: PADDR  input  ADDR_WIDTH  byte address.
- REQ-012: PWDATA  input  DATA_WIDTH  write data.
- REQ-013: PSTRB  input  STRB_WIDTH  write byte enables; ignored on reads.
- REQ-014: PRDATA  output  DATA_WIDTH  read data.
- REQ-015: PREADY  output  1  transfer-complete indicator.
- REQ-016: PSLVERR  output  1  transfer error indicator.

Function
- REQ-017: The FSM SHALL have three states: IDLE, SETUP, ACCESS.
- REQ-018: IDLE->SETUP SHALL occur when PSEL=1 and PENABLE=0; PSEL=1 with PENABLE=1 while in IDLE SHALL be ignored, leaving the FSM in IDLE.
- REQ-019: SETUP->ACCESS SHALL occur when PSEL=1 and PENABLE=1; SETUP SHALL latch PADDR, PWRITE, PWDATA and PSTRB on that edge.
- REQ-020: SETUP with PSEL=0 SHALL return to IDLE with no memory effect.
- REQ-021: A 4-bit wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle while below WAIT_STATES.
- REQ-022: PREADY SHALL be 1 only in ACCESS with counter equal to WAIT_STATES; read latency from setup SHALL be 2+WAIT_STATES cycles, and WAIT_STATES=0 SHALL give zero-wait transfers.
- REQ-023: On the edge ending ACCESS with PREADY=1:
  - PSEL=1, PENABLE=0 SHALL go to SETUP (back-to-back transfer).
  - Otherwise the FSM SHALL go to IDLE.
- REQ-024: PSEL or PENABLE dropping in ACCESS before PREADY SHALL abort to IDLE with no write.
- REQ-025: Word index SHALL be the latched PADDR[ADDR_WIDTH-1:2].
- REQ-026: An error SHALL be flagged if the index is >= MEM_DEPTH or PADDR[1:0] != 0.
- REQ-027: Writes SHALL commit on the completing edge only, updating byte i when PSTRB[i]=1 and no error; an error write or PSTRB=0 SHALL leave memory unchanged.
- REQ-028: PRDATA SHALL equal mem[index] while PREADY=1 on a non-error read, else all zeros.
- REQ-029: PSLVERR SHALL equal the error flag while PREADY=1, else 0.
- REQ-030: A read following a write to the same word SHALL return the updated data.

Reset
- REQ-031: PRESETn=0 SHALL immediately force state IDLE, counter 0, PREADY=0, PSLVERR=0, PRDATA=0, and all memory words 0.
- REQ-032: Reset asserted mid-ACCESS SHALL discard the in-flight transfer with no memory write.
- REQ-033: Deassertion SHALL be synchronous to PCLK; the first transfer SHALL be accepted on the first rising edge with PRESETn=1.

Verification
- REQ-034: Write 0xA5A5_1234 to 0x08 with PSTRB=4'hF, then read 0x08 -> PRDATA=0xA5A5_1234, PSLVERR=0; PREADY high on the 2nd access cycle (WAIT_STATES=1).
- REQ-035: Write 0xFFFF_FFFF to 0x10 with PSTRB=4'b0101 after reset, then read -> 0x00FF_00FF.
- REQ-036: Access 0x100 (ADDR_WIDTH=9) or 0x06 -> PSLVERR=1 with PREADY; read PRDATA=0; memory unchanged.
- REQ-037: Back-to-back write 0x04 then read 0x04 with no IDLE between -> second transfer completes correctly, SETUP entered directly from ACCESS.
- REQ-038: PRESETn low during ACCESS of a write to 0x0C -> PREADY=0 immediately; a later read of 0x0C returns 0.
- REQ-039: PSEL dropped during wait state -> FSM IDLE, no write; with WAIT_STATES=0, PREADY=1 in the first ACCESS cycle.
